axi_stream_skid_buffer: RTL and testbench
=========================================

# axi_stream_skid_buffer

Full-throughput AXI4-Stream register slice (two-entry skid buffer) that sits between an upstream stream master and a downstream slave, breaking the combinational TREADY path while sustaining one beat per cycle. Its master-side output must satisfy every handshake and stability rule that the downstream stream slave checker enforces. It also carries TSTRB/TKEEP/TLAST/TID/TDEST/TUSER unchanged and, optionally, reports beat and packet counts.

## Interface
- `byte_width`, 4, TDATA bytes; TDATA is 8*byte_width bits, TSTRB/TKEEP are byte_width bits.
- `id_width`, 0, TID width; 0 = signal unused (port is 1 bit, tie 0, output driven 0).
- `dest_width`, 0, TDEST width; 0 handling as for TID.
- `user_width`, 0, TUSER width; 0 handling as for TID.
- `clk  in  1  single clock; all logic on rising edge`
- `resetn  in  1  reset, asynchronous assert, active-low`
- `s_tvalid / s_tready  in / out  1  upstream handshake`
- `s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser  in  per params  upstream payload`
- `m_tvalid / m_tready  out / in  1  downstream handshake`
- `m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser  out  per params  downstream payload`
- `beat_count  out  32  completed m-side beats (only with stats macro)`
- `packet_count  out  32  completed m-side beats with m_tlast=1 (only with stats macro)`

## Operation
- Two payload registers: OUT (drives m_*) and SKID (holds one beat caught while downstream stalls).
- States: EMPTY (OUT invalid), ONE (OUT valid, SKID empty), FULL (both valid).
- s_tready = registered, equal to (state != FULL) outside reset; no combinational path from m_tready to s_tready.
- Upstream beat accepted when s_tvalid && s_tready; downstream beat retired when m_tvalid && m_tready.
- EMPTY: accept → load OUT, go ONE.
- ONE: accept && retire → reload OUT, stay ONE; accept && !retire → load SKID, go FULL; retire only → go EMPTY; neither → hold.
- FULL: retire → move SKID to OUT, go ONE; s_tready=0 so no accept.
- m_tvalid = (state != EMPTY). While m_tvalid && !m_tready all m_* payload holds bit-stable.
- m_tvalid never falls without a retire on the previous cycle (except reset).
- Payload passed bit-exact; no checking or modification of tstrb/tkeep combinations; beat order preserved.

## Timing
- Latency: beat accepted at edge N appears on m_* after edge N (valid in cycle N+1); no bypass path.
- Throughput: 1 beat/cycle with m_tready held high; sustained in ONE.
- Stall: at most one extra beat absorbed after m_tready drops (the one accepted in that same cycle).
- Reset (resetn low, asynchronous): state=EMPTY, m_tvalid=0, s_tready=0, all m_* payload=0, SKID cleared, counters=0.
- First edge after resetn rises: s_tready goes 1; m_tvalid stays 0 until a beat is accepted.
- Reset mid-transfer: buffered beats are discarded, no partial packet flushed.
- Counters (stats enabled) increment on retire; packet_count additionally requires m_tlast; both wrap 0xFFFFFFFF → 0.

## Configuration
- `AXIS_SKID_STATS_EN` defined: beat_count and packet_count ports and counters present.
- Not defined: ports absent, no counter flops; stream behaviour identical.

## Structure
- Shared package `axi_stream_pkg`: state encoding constants (EMPTY/ONE/FULL), counter width 32, helper for max(width,1) used to size zero-width sideband ports.
- One sub-module: `axi_stream_payload_reg` — load-enabled register for the concatenated payload bundle, instantiated twice (OUT, SKID).

## Test plan
- Reset then s_tvalid=1, data 0x11223344, tlast=1, m_tready=1 → m_tvalid rises one cycle later with 0x11223344; packet_count=1 after retire.
- Stream 0x00..0x0F back-to-back, m_tready=1 → 16 beats out in order, one per cycle, s_tready never drops.
- Beats 0xA, 0xB sent, m_tready=0 from cycle of 0xB → s_tready=0 next cycle, m_tdata holds 0xA stable; m_tready=1 → 0xA then 0xB emitted, s_tready returns to 1.
- Random s_tvalid / m_tready (50%), 1000 beats with downstream stream checker bound → zero property violations, output sequence equals input.
- Assert resetn low while FULL → m_tvalid and s_tready fall immediately (no edge), counters 0; after release no stale beat emitted.
- Counter wrap: preload beat_count to 0xFFFFFFFF via force, retire one beat → 0x00000000.

Source files
------------

// File: rtl/axi_stream_pkg.sv
// Shared definitions for the AXI4-Stream skid buffer: state encoding, counter width and
// the helper used to size sideband ports whose configured width may be zero.
package axi_stream_pkg;

  localparam int unsigned CountWidth = 32;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  // Zero-width sidebands still get a 1-bit port.
  function automatic int unsigned max1(input int unsigned width);
    return (width == 0) ? 1 : width;
  endfunction

endpackage

// File: rtl/axi_stream_payload_reg.sv
// Load-enabled register holding one concatenated stream payload bundle; cleared on reset.
module axi_stream_payload_reg
  import axi_stream_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic [Width-1:0] i_data,
  output logic [Width-1:0] o_data
);

  logic [Width-1:0] r_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/axi_stream_skid_buffer.sv
// Two-entry AXI4-Stream register slice: registered s_tready, one beat per cycle throughput.
// Define AXIS_SKID_STATS_EN to add the beat_count / packet_count outputs.
module axi_stream_skid_buffer
  import axi_stream_pkg::*;
#(
  parameter int unsigned byte_width = 4,
  parameter int unsigned id_width   = 0,
  parameter int unsigned dest_width = 0,
  parameter int unsigned user_width = 0
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic [8*byte_width-1:0]       s_tdata,
  input  logic [byte_width-1:0]         s_tstrb,
  input  logic [byte_width-1:0]         s_tkeep,
  input  logic                          s_tlast,
  input  logic [max1(id_width)-1:0]     s_tid,
  input  logic [max1(dest_width)-1:0]   s_tdest,
  input  logic [max1(user_width)-1:0]   s_tuser,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [8*byte_width-1:0]       m_tdata,
  output logic [byte_width-1:0]         m_tstrb,
  output logic [byte_width-1:0]         m_tkeep,
  output logic                          m_tlast,
  output logic [max1(id_width)-1:0]     m_tid,
  output logic [max1(dest_width)-1:0]   m_tdest,
  output logic [max1(user_width)-1:0]   m_tuser
`ifdef AXIS_SKID_STATS_EN
  ,
  output logic [CountWidth-1:0]         beat_count,
  output logic [CountWidth-1:0]         packet_count
`endif
);

  localparam int unsigned IdW      = max1(id_width);
  localparam int unsigned DestW    = max1(dest_width);
  localparam int unsigned UserW    = max1(user_width);
  localparam int unsigned PayloadW = 8 * byte_width + 2 * byte_width + 1 + IdW + DestW + UserW;

  state_e                r_state;
  logic                  r_s_tready;
  logic                  r_m_tvalid;
  logic                  w_accept;
  logic                  w_retire;
  logic                  w_out_load;
  logic                  w_out_sel_skid;
  logic                  w_skid_load;
  logic [IdW-1:0]        w_s_tid;
  logic [DestW-1:0]      w_s_tdest;
  logic [UserW-1:0]      w_s_tuser;
  logic [PayloadW-1:0]   w_s_payload;
  logic [PayloadW-1:0]   w_out_d;
  logic [PayloadW-1:0]   w_out_payload;
  logic [PayloadW-1:0]   w_skid_payload;

  // Unused sidebands are forced to zero so the outputs stay tied low.
  assign w_s_tid   = (id_width == 0)   ? '0 : s_tid;
  assign w_s_tdest = (dest_width == 0) ? '0 : s_tdest;
  assign w_s_tuser = (user_width == 0) ? '0 : s_tuser;

  assign w_s_payload = {s_tdata, s_tstrb, s_tkeep, s_tlast, w_s_tid, w_s_tdest, w_s_tuser};

  assign w_accept = s_tvalid && r_s_tready;
  assign w_retire = r_m_tvalid && m_tready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= StEmpty;
      r_s_tready <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else begin
      case (r_state)
        StEmpty: begin
          r_s_tready <= 1'b1;
          if (w_accept) begin
            r_state    <= StOne;
            r_m_tvalid <= 1'b1;
          end
        end
        StOne: begin
          if (w_accept && !w_retire) begin
            r_state    <= StFull;
            r_s_tready <= 1'b0;
          end else if (!w_accept && w_retire) begin
            r_state    <= StEmpty;
            r_m_tvalid <= 1'b0;
            r_s_tready <= 1'b1;
          end else begin
            r_s_tready <= 1'b1;
          end
        end
        StFull: begin
          if (w_retire) begin
            r_state    <= StOne;
            r_s_tready <= 1'b1;
          end
        end
        default: begin
          r_state    <= StEmpty;
          r_s_tready <= 1'b0;
          r_m_tvalid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_out_load     = 1'b0;
    w_out_sel_skid = 1'b0;
    w_skid_load    = 1'b0;
    case (r_state)
      StEmpty: w_out_load = w_accept;
      StOne: begin
        w_out_load  = w_accept && w_retire;
        w_skid_load = w_accept && !w_retire;
      end
      StFull: begin
        w_out_load     = w_retire;
        w_out_sel_skid = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_out_d = w_out_sel_skid ? w_skid_payload : w_s_payload;

  axi_stream_payload_reg #(
    .Width (PayloadW)
  ) u_out_reg (
    .clk    (clk),
    .resetn (resetn),
    .i_load (w_out_load),
    .i_data (w_out_d),
    .o_data (w_out_payload)
  );

  axi_stream_payload_reg #(
    .Width (PayloadW)
  ) u_skid_reg (
    .clk    (clk),
    .resetn (resetn),
    .i_load (w_skid_load),
    .i_data (w_s_payload),
    .o_data (w_skid_payload)
  );

  assign s_tready = r_s_tready;
  assign m_tvalid = r_m_tvalid;
  assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = w_out_payload;

`ifdef AXIS_SKID_STATS_EN
  logic [CountWidth-1:0] r_beat_count;
  logic [CountWidth-1:0] r_packet_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_beat_count   <= '0;
      r_packet_count <= '0;
    end else if (w_retire) begin
      r_beat_count <= r_beat_count + 1'b1;
      if (m_tlast) begin
        r_packet_count <= r_packet_count + 1'b1;
      end
    end
  end

  assign beat_count   = r_beat_count;
  assign packet_count = r_packet_count;
`endif

endmodule

// File: tb/tb_axi_stream_skid_buffer.sv
// Scoreboard bench for axi_stream_skid_buffer: directed scenarios plus random valid/ready traffic.
// Counter checks are compiled in when AXIS_SKID_STATS_EN is defined.
module tb_axi_stream_skid_buffer;

  localparam int unsigned BW   = 4;
  localparam int unsigned IDW  = 3;
  localparam int unsigned DSTW = 2;
  localparam int unsigned USW  = 4;
  localparam int unsigned PW   = 8 * BW + 2 * BW + 1 + IDW + DSTW + USW;
  localparam int unsigned LastBit = IDW + DSTW + USW;

  logic              clk;
  logic              resetn;
  logic              s_tvalid;
  logic              s_tready;
  logic [8*BW-1:0]   s_tdata;
  logic [BW-1:0]     s_tstrb;
  logic [BW-1:0]     s_tkeep;
  logic              s_tlast;
  logic [IDW-1:0]    s_tid;
  logic [DSTW-1:0]   s_tdest;
  logic [USW-1:0]    s_tuser;
  logic              m_tvalid;
  logic              m_tready;
  logic [8*BW-1:0]   m_tdata;
  logic [BW-1:0]     m_tstrb;
  logic [BW-1:0]     m_tkeep;
  logic              m_tlast;
  logic [IDW-1:0]    m_tid;
  logic [DSTW-1:0]   m_tdest;
  logic [USW-1:0]    m_tuser;
`ifdef AXIS_SKID_STATS_EN
  logic [31:0]       beat_count;
  logic [31:0]       packet_count;
`endif

  logic [PW-1:0] s_pl;
  logic [PW-1:0] m_pl;
  assign s_pl = {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
  assign m_pl = {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};

  axi_stream_skid_buffer #(
    .byte_width (BW),
    .id_width   (IDW),
    .dest_width (DSTW),
    .user_width (USW)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tstrb  (s_tstrb),
    .s_tkeep  (s_tkeep),
    .s_tlast  (s_tlast),
    .s_tid    (s_tid),
    .s_tdest  (s_tdest),
    .s_tuser  (s_tuser),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tstrb  (m_tstrb),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast),
    .m_tid    (m_tid),
    .m_tdest  (m_tdest),
    .m_tuser  (m_tuser)
`ifdef AXIS_SKID_STATS_EN
    ,
    .beat_count   (beat_count),
    .packet_count (packet_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  int unsigned   n_retired = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] prev_pl;
  logic [PW-1:0] exp_beat;
  logic          prev_stall = 1'b0;
  logic          armed;
  logic [31:0]   exp_beats = '0;
  logic [31:0]   exp_pkts = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Set once an edge has occurred with reset released; s_tready may only be high after that.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) armed <= 1'b0;
    else         armed <= 1'b1;
  end

  // Monitor: the model is just the FIFO of accepted-but-not-retired beats.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      prev_stall = 1'b0;
      exp_beats  = '0;
      exp_pkts   = '0;
    end else begin
      chk("m_tvalid_vs_occupancy", 64'(m_tvalid), 64'(exp_q.size() != 0));
      chk("s_tready_vs_occupancy", 64'(s_tready), 64'(armed && exp_q.size() < 2));
      if (prev_stall) chk("stall_hold", 64'(m_pl), 64'(prev_pl));
`ifdef AXIS_SKID_STATS_EN
      chk("beat_count", 64'(beat_count), 64'(exp_beats));
      chk("packet_count", 64'(packet_count), 64'(exp_pkts));
`endif
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 64'(1), 64'(0));
        end else begin
          exp_beat = exp_q.pop_front();
          chk("beat_payload", 64'(m_pl), 64'(exp_beat));
          exp_beats = exp_beats + 32'd1;
          if (exp_beat[LastBit]) exp_pkts = exp_pkts + 32'd1;
        end
        n_retired++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_pl    = m_pl;
      if (s_tvalid && s_tready) exp_q.push_back(s_pl);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [31:0] data, input logic last);
    s_tdata = data;
    s_tstrb = 4'hF;
    s_tkeep = 4'hF;
    s_tlast = last;
    s_tid   = data[2:0];
    s_tdest = data[4:3];
    s_tuser = data[8:5];
  endtask

  task automatic rand_beat();
    s_tdata = $urandom;
    s_tstrb = 4'($urandom);
    s_tkeep = 4'($urandom);
    s_tlast = 1'($urandom);
    s_tid   = 3'($urandom);
    s_tdest = 2'($urandom);
    s_tuser = 4'($urandom);
  endtask

  initial begin
    int unsigned base;
    int unsigned sent;
    int unsigned cyc;
    logic        acc;

    resetn   = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    set_beat(32'h0, 1'b0);
    repeat (3) step();

    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    chk("rst_payload", 64'(m_pl), 64'(0));
    resetn = 1'b1;
    step();
    chk("post_rst_s_tready", 64'(s_tready), 64'(1));
    chk("post_rst_m_tvalid", 64'(m_tvalid), 64'(0));

    // Single beat: visible one cycle after acceptance.
    set_beat(32'h11223344, 1'b1);
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    step();
    s_tvalid = 1'b0;
    chk("single_m_tvalid", 64'(m_tvalid), 64'(1));
    chk("single_m_tdata", 64'(m_tdata), 64'h11223344);
    step();
    step();
`ifdef AXIS_SKID_STATS_EN
    chk("single_packet_count", 64'(packet_count), 64'(1));
`endif

    // Back-to-back burst at full rate.
    base = n_retired;
    s_tvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_beat(32'(i), i == 15);
      step();
      chk("burst_s_tready", 64'(s_tready), 64'(1));
    end
    s_tvalid = 1'b0;
    repeat (3) step();
    chk("burst_retired", 64'(n_retired - base), 64'(16));

    // Stall: 0xA then 0xB with m_tready dropping in the cycle of 0xB.
    set_beat(32'hA, 1'b0);
    s_tvalid = 1'b1;
    step();
    set_beat(32'hB, 1'b1);
    m_tready = 1'b0;
    step();
    s_tvalid = 1'b0;
    chk("stall_s_tready", 64'(s_tready), 64'(0));
    chk("stall_m_tdata", 64'(m_tdata), 64'hA);
    step();
    chk("stall_m_tdata_hold", 64'(m_tdata), 64'hA);
    m_tready = 1'b1;
    step();
    chk("unstall_m_tdata", 64'(m_tdata), 64'hB);
    chk("unstall_s_tready", 64'(s_tready), 64'(1));
    step();
    chk("unstall_drained", 64'(m_tvalid), 64'(0));

    // Random traffic; an offered beat is held until accepted.
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      if (!s_tvalid && $urandom_range(1, 0) == 1) begin
        rand_beat();
        s_tvalid = 1'b1;
      end
      m_tready = 1'($urandom_range(1, 0));
      @(negedge clk);
      acc = s_tvalid && s_tready;
      step();
      cyc++;
      if (acc) begin
        sent++;
        s_tvalid = 1'b0;
      end
    end
    chk("random_sent_in_budget", 64'(sent), 64'(1000));
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (4) step();
    chk("random_drained", 64'(exp_q.size()), 64'(0));

    // Reset while FULL: everything drops without a clock edge.
    m_tready = 1'b0;
    set_beat(32'hC0, 1'b0);
    s_tvalid = 1'b1;
    step();
    set_beat(32'hD0, 1'b1);
    step();
    s_tvalid = 1'b0;
    chk("full_s_tready", 64'(s_tready), 64'(0));
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("async_rst_s_tready", 64'(s_tready), 64'(0));
    chk("async_rst_payload", 64'(m_pl), 64'(0));
`ifdef AXIS_SKID_STATS_EN
    chk("async_rst_beat_count", 64'(beat_count), 64'(0));
    chk("async_rst_packet_count", 64'(packet_count), 64'(0));
`endif
    step();
    resetn   = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("no_stale_beat", 64'(m_tvalid), 64'(0));
    end

`ifdef AXIS_SKID_STATS_EN
    // Counter wrap from all-ones.
    exp_beats = 32'hFFFF_FFFF;
    force dut.r_beat_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_beat_count;
    step();
    set_beat(32'h5A5A5A5A, 1'b0);
    s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    step();
    chk("beat_count_wrap", 64'(beat_count), 64'(0));
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
